// File: rtl/wb_queue_if.sv
// Write-back queue bus: two producer request channels, register-file write
// port, pending-write lookup and occupancy.
interface wb_queue_if #(
    parameter int N     = 5,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Valid/ready: a producer raises valid with addr/data stable; the request
    // is taken at the rising edge where valid & ready are both high. ready is
    // a function of queue state and a_valid only, never of the same port's valid.
    logic          a_valid;
    logic          a_ready;
    logic [N-1:0]  a_addr;
    logic [31:0]   a_data;
    logic          b_valid;
    logic          b_ready;
    logic [N-1:0]  b_addr;
    logic [31:0]   b_data;
    logic          we;
    logic [N-1:0]  wa;
    logic [31:0]   wd;
    logic [N-1:0]  chk_addr;
    logic          chk_pending;
    logic [31:0]   chk_data;
    logic [CW-1:0] count;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, chk_addr,
        input  a_ready, b_ready, we, wa, wd, chk_pending, chk_data, count
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, chk_addr,
        output a_ready, b_ready, we, wa, wd, chk_pending, chk_data, count
    );
endinterface

// File: rtl/wb_queue.sv
// In-order write-back FIFO with two producers, one register-file write per
// cycle, and a youngest-match pending-write lookup for bypass logic.
module wb_queue #(
    parameter int N     = 5,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] cnt;
    logic [N-1:0]  mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];

    logic [CW-1:0] free;
    logic          a_live;
    logic          a_rdy;
    logic          b_rdy;
    logic          a_push;
    logic          b_push;
    logic          pop;
    logic [AW-1:0] b_slot;

    // Free space ignores the same-cycle pop, so readies never depend on drain.
    assign free   = CW'(DEPTH) - cnt;
    assign a_live = q.a_valid && (q.a_addr != '0);
    assign a_rdy  = (free >= CW'(1));
    assign b_rdy  = (free >= CW'(2)) || ((free == CW'(1)) && !a_live);
    assign a_push = a_live && a_rdy;
    assign b_push = q.b_valid && b_rdy && (q.b_addr != '0);
    assign pop    = (cnt != '0);
    assign b_slot = tail + AW'(a_push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + AW'(pop);
            tail <= tail + AW'(a_push) + AW'(b_push);
            cnt  <= cnt + CW'(a_push) + CW'(b_push) - CW'(pop);
        end
    end

    // Payload storage needs no reset: only entries covered by cnt are ever read.
    always_ff @(posedge clk) begin
        if (a_push) begin
            mem_addr[tail] <= q.a_addr;
            mem_data[tail] <= q.a_data;
        end
        if (b_push) begin
            mem_addr[b_slot] <= q.b_addr;
            mem_data[b_slot] <= q.b_data;
        end
    end

    assign q.a_ready = a_rdy;
    assign q.b_ready = b_rdy;
    assign q.count   = cnt;
    assign q.we      = pop;
    assign q.wa      = pop ? mem_addr[head] : '0;
    assign q.wd      = pop ? mem_data[head] : '0;

    // Walk oldest to youngest so the last hit is the youngest match.
    logic          hit;
    logic [31:0]   hit_data;
    logic [AW-1:0] idx;

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if ((CW'(i) < cnt) && (q.chk_addr != '0) && (mem_addr[idx] == q.chk_addr)) begin
                hit      = 1'b1;
                hit_data = mem_data[idx];
            end
        end
    end

    assign q.chk_pending = hit;
    assign q.chk_data    = hit_data;
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: DEPTH=4 main instance plus a DEPTH=2 instance
// used to reach the full condition.
module tb_wb_queue;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [36:0] exp_q[$];

    wb_queue_if #(.N(5), .DEPTH(4)) bus ();
    wb_queue_if #(.N(5), .DEPTH(2)) bus2 ();

    wb_queue #(.N(5), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .q(bus));
    wb_queue #(.N(5), .DEPTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .q(bus2));

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [4:0] addr, input logic [31:0] data);
        bus.a_valid = 1'b1;
        bus.a_addr  = addr;
        bus.a_data  = data;
    endtask

    task automatic drive_b(input logic [4:0] addr, input logic [31:0] data);
        bus.b_valid = 1'b1;
        bus.b_addr  = addr;
        bus.b_data  = data;
    endtask

    task automatic idle();
        bus.a_valid = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;
    endtask

    task automatic idle2();
        bus2.a_valid = 1'b0;
        bus2.a_addr  = '0;
        bus2.a_data  = '0;
        bus2.b_valid = 1'b0;
        bus2.b_addr  = '0;
        bus2.b_data  = '0;
        bus2.chk_addr = '0;
    endtask

    // Scoreboard drain: each expected entry appears on the write port in order.
    task automatic drain_check(input string tag);
        logic [36:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_we"}, 32'(bus.we), 1);
            check({tag, "_wa"}, 32'(bus.wa), 32'(e[36:32]));
            check({tag, "_wd"}, bus.wd, e[31:0]);
            tick();
        end
        check({tag, "_empty_we"}, 32'(bus.we), 0);
        check({tag, "_empty_count"}, 32'(bus.count), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        idle2();
        bus.chk_addr = 5'd3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(bus.we), 0);
        check("rst_wa", 32'(bus.wa), 0);
        check("rst_wd", bus.wd, 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_pending", 32'(bus.chk_pending), 0);
        check("rst_chk_data", bus.chk_data, 0);
        check("rst_a_ready", 32'(bus.a_ready), 1);
        check("rst_b_ready", 32'(bus.b_ready), 1);
        rst_n = 1'b1;
        tick();

        // single push
        drive_a(5'd3, 32'hDEADBEEF);
        #1 check("single_a_ready", 32'(bus.a_ready), 1);
        tick();
        idle();
        check("single_we", 32'(bus.we), 1);
        check("single_wa", 32'(bus.wa), 3);
        check("single_wd", bus.wd, 32'hDEADBEEF);
        check("single_count", 32'(bus.count), 1);
        tick();
        check("single_done_we", 32'(bus.we), 0);
        check("single_done_count", 32'(bus.count), 0);
        check("single_done_wa", 32'(bus.wa), 0);
        check("single_done_wd", bus.wd, 0);

        // dual push ordering
        drive_a(5'd5, 32'h11);
        drive_b(5'd6, 32'h22);
        #1;
        check("dual_a_ready", 32'(bus.a_ready), 1);
        check("dual_b_ready", 32'(bus.b_ready), 1);
        tick();
        idle();
        check("dual_count", 32'(bus.count), 2);
        exp_q.push_back({5'd5, 32'h11});
        exp_q.push_back({5'd6, 32'h22});
        drain_check("dual");

        // backpressure while draining: occupancy settles at 3 with DEPTH=4
        drive_a(5'd1, 32'hA0);
        drive_b(5'd2, 32'hB0);
        #1 check("fill0_b_ready", 32'(bus.b_ready), 1);
        tick();
        drive_a(5'd3, 32'hA1);
        drive_b(5'd8, 32'hB1);
        #1;
        check("fill1_count", 32'(bus.count), 2);
        check("fill1_wa", 32'(bus.wa), 1);
        check("fill1_a_ready", 32'(bus.a_ready), 1);
        check("fill1_b_ready", 32'(bus.b_ready), 1);
        tick();
        drive_a(5'd10, 32'hA2);
        drive_b(5'd11, 32'hB2);
        #1;
        check("fill2_count", 32'(bus.count), 3);
        check("fill2_wa", 32'(bus.wa), 2);
        check("fill2_a_ready", 32'(bus.a_ready), 1);
        check("fill2_b_ready", 32'(bus.b_ready), 0);
        tick();
        idle();
        #1;
        check("fill3_count", 32'(bus.count), 3);
        check("fill3_b_ready_no_a", 32'(bus.b_ready), 1);
        exp_q.push_back({5'd3, 32'hA1});
        exp_q.push_back({5'd8, 32'hB1});
        exp_q.push_back({5'd10, 32'hA2});
        drain_check("fill");

        // register zero at free==1 does not block B
        drive_a(5'd12, 32'hC0);
        drive_b(5'd13, 32'hC1);
        tick();
        drive_a(5'd14, 32'hC2);
        drive_b(5'd15, 32'hC3);
        tick();
        drive_a(5'd0, 32'h55);
        drive_b(5'd7, 32'h66);
        #1;
        check("zero_count_before", 32'(bus.count), 3);
        check("zero_a_ready", 32'(bus.a_ready), 1);
        check("zero_b_ready", 32'(bus.b_ready), 1);
        tick();
        idle();
        check("zero_count_after", 32'(bus.count), 3);
        exp_q.push_back({5'd14, 32'hC2});
        exp_q.push_back({5'd15, 32'hC3});
        exp_q.push_back({5'd7, 32'h66});
        drain_check("zero");
        drive_a(5'd0, 32'h55);
        #1 check("zero_only_a_ready", 32'(bus.a_ready), 1);
        tick();
        idle();
        check("zero_only_count", 32'(bus.count), 0);
        check("zero_only_we", 32'(bus.we), 0);

        // forwarding: queue becomes (9,1),(4,2),(9,3)
        drive_a(5'd7, 32'h0);
        drive_b(5'd9, 32'h1);
        tick();
        drive_a(5'd4, 32'h2);
        drive_b(5'd9, 32'h3);
        tick();
        idle();
        bus.chk_addr = 5'd9;
        #1;
        check("fwd_count", 32'(bus.count), 3);
        check("fwd9_pending", 32'(bus.chk_pending), 1);
        check("fwd9_data", bus.chk_data, 32'h3);
        bus.chk_addr = 5'd4;
        #1 check("fwd4_data", bus.chk_data, 32'h2);
        bus.chk_addr = 5'd0;
        #1;
        check("fwd0_pending", 32'(bus.chk_pending), 0);
        check("fwd0_data", bus.chk_data, 0);
        bus.chk_addr = 5'd12;
        #1 check("fwd12_pending", 32'(bus.chk_pending), 0);
        bus.chk_addr = 5'd9;
        tick();
        tick();
        check("fwd_head_pending", 32'(bus.chk_pending), 1);
        check("fwd_head_data", bus.chk_data, 32'h3);
        tick();
        check("fwd_drained_pending", 32'(bus.chk_pending), 0);
        check("fwd_drained_data", bus.chk_data, 0);

        // asynchronous reset mid-operation
        drive_a(5'd1, 32'h1);
        drive_b(5'd2, 32'h2);
        tick();
        drive_a(5'd3, 32'h3);
        drive_b(5'd4, 32'h4);
        tick();
        idle();
        bus.chk_addr = 5'd3;
        #1;
        check("arst_pre_count", 32'(bus.count), 3);
        check("arst_pre_pending", 32'(bus.chk_pending), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we", 32'(bus.we), 0);
        check("arst_count", 32'(bus.count), 0);
        check("arst_pending", 32'(bus.chk_pending), 0);
        check("arst_chk_data", bus.chk_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("arst_post_we0", 32'(bus.we), 0);
        tick();
        check("arst_post_we1", 32'(bus.we), 0);
        check("arst_post_count", 32'(bus.count), 0);

        // full condition on the DEPTH=2 instance
        bus2.a_valid = 1'b1; bus2.a_addr = 5'd1; bus2.a_data = 32'h71;
        bus2.b_valid = 1'b1; bus2.b_addr = 5'd2; bus2.b_data = 32'h72;
        #1;
        check("full_a_ready0", 32'(bus2.a_ready), 1);
        check("full_b_ready0", 32'(bus2.b_ready), 1);
        tick();
        bus2.a_addr = 5'd3; bus2.a_data = 32'h73;
        bus2.b_addr = 5'd4; bus2.b_data = 32'h74;
        #1;
        check("full_count", 32'(bus2.count), 2);
        check("full_a_ready", 32'(bus2.a_ready), 0);
        check("full_b_ready", 32'(bus2.b_ready), 0);
        check("full_wa", 32'(bus2.wa), 1);
        tick();
        check("full_next_count", 32'(bus2.count), 1);
        check("full_next_a_ready", 32'(bus2.a_ready), 1);
        check("full_next_b_ready", 32'(bus2.b_ready), 0);
        check("full_next_wa", 32'(bus2.wa), 2);
        idle2();
        tick();
        tick();
        check("full_drained_we", 32'(bus2.we), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
